// File: rtl/sram_arb_pkg.sv
// rtl/sram_arb_pkg.sv - shared widths, burst limit and port indices for the SRAM arbiter
package sram_arb_pkg;

  localparam int DEF_ADDR_WIDTH = 9;
  localparam int DEF_DATA_WIDTH = 8;
  localparam int DEF_MAX_BURST  = 16;

  localparam logic PORT0 = 1'b0;
  localparam logic PORT1 = 1'b1;

  // burst_cnt must hold 0..max_burst inclusive
  function automatic int cnt_width(input int max_burst);
    return $clog2(max_burst + 1);
  endfunction

endpackage

// File: rtl/sram_arb_pick.sv
// rtl/sram_arb_pick.sv - combinational round-robin pick with lock-burst hold
module sram_arb_pick
  import sram_arb_pkg::*;
(
  input  logic req0,
  input  logic req1,
  input  logic last_gnt,
  input  logic lock_reg,
  input  logic burst_ok,
  output logic gnt0,
  output logic gnt1,
  output logic sel
);

  // sel rests on port 0 when idle so the RAM address mux has a fixed source
  always_comb begin
    sel  = PORT0;
    gnt0 = 1'b0;
    gnt1 = 1'b0;
    if (req0 && req1) begin
      sel = (lock_reg && burst_ok) ? last_gnt : ~last_gnt;
    end else if (req1) begin
      sel = PORT1;
    end
    gnt0 = (req0 || req1) && (sel == PORT0);
    gnt1 = (req0 || req1) && (sel == PORT1);
  end

endmodule

// File: rtl/sram_arbiter.sv
// rtl/sram_arbiter.sv - two-port round-robin arbiter in front of a single-port synchronous SRAM
module sram_arbiter
  import sram_arb_pkg::*;
#(
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int MAX_BURST  = DEF_MAX_BURST
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req0,
  input  logic                  we0,
  input  logic [ADDR_WIDTH-1:0] addr0,
  input  logic [DATA_WIDTH-1:0] wdata0,
  input  logic                  lock0,
  input  logic                  req1,
  input  logic                  we1,
  input  logic [ADDR_WIDTH-1:0] addr1,
  input  logic [DATA_WIDTH-1:0] wdata1,
  input  logic                  lock1,
  output logic                  gnt0,
  output logic                  gnt1,
  output logic                  rvalid0,
  output logic                  rvalid1,
  output logic [DATA_WIDTH-1:0] rdata,
  output logic [ADDR_WIDTH-1:0] ram_addr,
  output logic [DATA_WIDTH-1:0] ram_din,
  output logic                  ram_we,
  input  logic [DATA_WIDTH-1:0] ram_dout
);

  localparam int            CW      = cnt_width(MAX_BURST);
  localparam logic [CW-1:0] MAX_CNT = CW'(MAX_BURST);

  logic          last_gnt;
  logic          lock_reg;
  logic [CW-1:0] burst_cnt;
  logic          pick_gnt0;
  logic          pick_gnt1;
  logic          sel;
  logic          burst_ok;
  logic          any_gnt;
  logic [CW-1:0] burst_inc;

  assign burst_ok = (burst_cnt < MAX_CNT);

  sram_arb_pick u_pick (
    .req0     (req0),
    .req1     (req1),
    .last_gnt (last_gnt),
    .lock_reg (lock_reg),
    .burst_ok (burst_ok),
    .gnt0     (pick_gnt0),
    .gnt1     (pick_gnt1),
    .sel      (sel)
  );

  // Grants are masked while reset is held so no RAM write can slip through
  assign gnt0    = pick_gnt0 & rst_n;
  assign gnt1    = pick_gnt1 & rst_n;
  assign any_gnt = gnt0 | gnt1;

  assign ram_addr = (sel == PORT1) ? addr1  : addr0;
  assign ram_din  = (sel == PORT1) ? wdata1 : wdata0;
  assign ram_we   = (gnt0 & we0) | (gnt1 & we1);
  assign rdata    = ram_dout;

  assign burst_inc = (burst_cnt == MAX_CNT) ? MAX_CNT : burst_cnt + CW'(1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_gnt  <= PORT1;
      lock_reg  <= 1'b0;
      burst_cnt <= '0;
      rvalid0   <= 1'b0;
      rvalid1   <= 1'b0;
    end else begin
      rvalid0 <= gnt0 & ~we0;
      rvalid1 <= gnt1 & ~we1;
      if (any_gnt) begin
        last_gnt  <= sel;
        lock_reg  <= (sel == PORT1) ? lock1 : lock0;
        burst_cnt <= (sel == last_gnt) ? burst_inc : CW'(1);
      end else begin
        // an idle cycle ends any burst
        lock_reg  <= 1'b0;
        burst_cnt <= '0;
      end
    end
  end

endmodule

// File: tb/tb_sram_arbiter.sv
// tb/tb_sram_arbiter.sv - directed bench with behavioural arbitration/memory model and per-cycle compare
module tb_sram_arbiter;

  localparam int AW = 9;
  localparam int DW = 8;
  localparam int MB = 4;

  logic          clk    = 1'b0;
  logic          rst_n  = 1'b0;
  logic          req0   = 1'b0;
  logic          we0    = 1'b0;
  logic [AW-1:0] addr0  = '0;
  logic [DW-1:0] wdata0 = '0;
  logic          lock0  = 1'b0;
  logic          req1   = 1'b0;
  logic          we1    = 1'b0;
  logic [AW-1:0] addr1  = '0;
  logic [DW-1:0] wdata1 = '0;
  logic          lock1  = 1'b0;
  logic          gnt0, gnt1, rvalid0, rvalid1, ram_we;
  logic [DW-1:0] rdata, ram_din, ram_dout;
  logic [AW-1:0] ram_addr;

  int n_tests = 0;
  int n_fail  = 0;

  sram_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .MAX_BURST(MB)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0(req0), .we0(we0), .addr0(addr0), .wdata0(wdata0), .lock0(lock0),
    .req1(req1), .we1(we1), .addr1(addr1), .wdata1(wdata1), .lock1(lock1),
    .gnt0(gnt0), .gnt1(gnt1), .rvalid0(rvalid0), .rvalid1(rvalid1), .rdata(rdata),
    .ram_addr(ram_addr), .ram_din(ram_din), .ram_we(ram_we), .ram_dout(ram_dout)
  );

  always #5 clk = ~clk;

  function automatic logic [DW-1:0] pre(input int a);
    return DW'((a * 37 + 11) & 255);
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Synchronous RAM, contents survive reset
  logic [DW-1:0] ram [0:511];
  logic [DW-1:0] shadow [0:511];
  initial begin
    for (int i = 0; i < 512; i++) begin
      ram[i]    = pre(i);
      shadow[i] = pre(i);
    end
  end
  always @(posedge clk) begin
    if (ram_we) ram[ram_addr] <= ram_din;
    ram_dout <= ram[ram_addr];
  end

  // Model: winner from the arbitration rules; run length is left uncapped
  int            m_last, m_run, m_win;
  logic          m_lock, m_rv0, m_rv1;
  logic [DW-1:0] m_rd;

  function automatic int pick_model(input logic r0, input logic r1, input int last,
                                    input logic lk, input int run);
    if (r0 && r1) return (lk && run < MB) ? last : 1 - last;
    if (r0) return 0;
    if (r1) return 1;
    return -1;
  endfunction

  always_comb m_win = pick_model(req0, req1, m_last, m_lock, m_run);

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_last <= 1;
      m_lock <= 1'b0;
      m_run  <= 0;
      m_rv0  <= 1'b0;
      m_rv1  <= 1'b0;
    end else begin
      m_rv0 <= (m_win == 0) && !we0;
      m_rv1 <= (m_win == 1) && !we1;
      if (m_win == 0) begin
        m_run  <= (m_last == 0) ? m_run + 1 : 1;
        m_last <= 0;
        m_lock <= lock0;
        if (we0) shadow[addr0] <= wdata0;
        else     m_rd <= shadow[addr0];
      end else if (m_win == 1) begin
        m_run  <= (m_last == 1) ? m_run + 1 : 1;
        m_last <= 1;
        m_lock <= lock1;
        if (we1) shadow[addr1] <= wdata1;
        else     m_rd <= shadow[addr1];
      end else begin
        m_lock <= 1'b0;
        m_run  <= 0;
      end
    end
  end

  always @(negedge clk) begin
    if (!rst_n) begin
      check("rst_gnt0", gnt0, 0);
      check("rst_gnt1", gnt1, 0);
      check("rst_ram_we", ram_we, 0);
      check("rst_rvalid", {rvalid1, rvalid0}, 0);
    end else begin
      check("m_gnt0", gnt0, m_win == 0);
      check("m_gnt1", gnt1, m_win == 1);
      check("m_ram_we", ram_we, (m_win == 0 && we0) || (m_win == 1 && we1));
      if (m_win == 0) begin
        check("m_ram_addr0", ram_addr, addr0);
        check("m_ram_din0", ram_din, wdata0);
      end else if (m_win == 1) begin
        check("m_ram_addr1", ram_addr, addr1);
        check("m_ram_din1", ram_din, wdata1);
      end
      check("m_rvalid0", rvalid0, m_rv0);
      check("m_rvalid1", rvalid1, m_rv1);
      if (m_rv0 || m_rv1) check("m_rdata", rdata, m_rd);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    req0 = 1'b0; we0 = 1'b0; lock0 = 1'b0;
    req1 = 1'b0; we1 = 1'b0; lock1 = 1'b0;
  endtask

  task automatic set0(input logic r, input logic w, input logic [AW-1:0] a,
                      input logic [DW-1:0] d, input logic l);
    req0 = r; we0 = w; addr0 = a; wdata0 = d; lock0 = l;
  endtask

  task automatic set1(input logic r, input logic w, input logic [AW-1:0] a,
                      input logic [DW-1:0] d, input logic l);
    req1 = r; we1 = w; addr1 = a; wdata1 = d; lock1 = l;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
  endtask

  logic [5:0] exp3;
  int         run1;
  logic       seen0;

  initial begin
    idle();
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    #2;
    check("reset_gnt", {gnt1, gnt0}, 0);
    check("reset_rvalid", {rvalid1, rvalid0}, 0);
    tick();

    // single writer: write then read back
    set0(1'b1, 1'b1, 9'h1F0, 8'hA5, 1'b0);
    #2;
    check("t1_wr_gnt0", gnt0, 1);
    check("t1_wr_we", ram_we, 1);
    tick();
    set0(1'b1, 1'b0, 9'h1F0, 8'h00, 1'b0);
    #2;
    check("t1_rd_gnt0", gnt0, 1);
    tick();
    idle();
    #2;
    check("t1_rvalid0", rvalid0, 1);
    check("t1_rdata", rdata, 8'hA5);
    check("t1_rvalid1", rvalid1, 0);
    tick();

    // contention without lock
    do_reset();
    set0(1'b1, 1'b0, 9'h010, 8'h00, 1'b0);
    set1(1'b1, 1'b0, 9'h020, 8'h00, 1'b0);
    for (int i = 0; i < 5; i++) begin
      #2;
      if (i > 0) begin
        check("t2_rvalid0", rvalid0, ((i - 1) % 2) == 0);
        check("t2_rvalid1", rvalid1, ((i - 1) % 2) == 1);
        check("t2_rdata", rdata, pre(((i - 1) % 2 == 0) ? 32'h010 : 32'h020));
      end
      if (i < 4) begin
        check("t2_gnt0", gnt0, (i % 2) == 0);
        check("t2_gnt1", gnt1, (i % 2) == 1);
      end
      tick();
      if (i == 3) idle();
    end

    // locked burst by port 1, capped at MB grants under contention
    set1(1'b1, 1'b0, 9'h030, 8'h00, 1'b1);
    #2;
    check("t3_lone_gnt1", gnt1, 1);
    tick();
    set0(1'b1, 1'b0, 9'h040, 8'h00, 1'b0);
    exp3  = 6'b010111;
    run1  = 1;
    seen0 = 1'b0;
    for (int i = 0; i < 6; i++) begin
      if (i == 3) lock1 = 1'b0;
      #2;
      check("t3_gnt1", gnt1, exp3[i]);
      check("t3_gnt0", gnt0, !exp3[i]);
      if (gnt0) seen0 = 1'b1;
      if (gnt1 && !seen0) run1++;
      tick();
    end
    check("t3_burst_len", run1, 4);
    idle();
    tick();

    // lone locked requester exceeds MB, then an idle cycle breaks the lock
    set0(1'b1, 1'b0, 9'h050, 8'h00, 1'b1);
    for (int i = 0; i < 6; i++) begin
      #2;
      check("t4_lone_gnt0", gnt0, 1);
      tick();
    end
    idle();
    tick();
    set0(1'b1, 1'b0, 9'h050, 8'h00, 1'b1);
    set1(1'b1, 1'b0, 9'h060, 8'h00, 1'b0);
    #2;
    check("t4_burst_cnt", dut.burst_cnt, 0);
    check("t4_gnt1", gnt1, 1);
    check("t4_gnt0", gnt0, 0);
    tick();
    idle();
    tick();

    // write by port 0, read of the same address by port 1 next cycle
    set0(1'b1, 1'b1, 9'h000, 8'h3C, 1'b0);
    #2;
    check("t5_wr_gnt0", gnt0, 1);
    tick();
    idle();
    set1(1'b1, 1'b0, 9'h000, 8'h00, 1'b0);
    #2;
    check("t5_rd_gnt1", gnt1, 1);
    tick();
    idle();
    #2;
    check("t5_rvalid1", rvalid1, 1);
    check("t5_rdata", rdata, 8'h3C);
    tick();

    // async reset between a read grant and its return
    set0(1'b1, 1'b0, 9'h055, 8'h00, 1'b0);
    tick();
    idle();
    #1;
    check("t6_rvalid0_pre", rvalid0, 1);
    rst_n = 1'b0;
    set0(1'b1, 1'b1, 9'h055, 8'hFF, 1'b0);
    set1(1'b1, 1'b0, 9'h066, 8'h00, 1'b0);
    #1;
    check("t6_rvalid0_drop", rvalid0, 0);
    check("t6_rst_gnt", {gnt1, gnt0}, 0);
    check("t6_rst_we", ram_we, 0);
    tick();
    rst_n = 1'b1;
    set0(1'b1, 1'b0, 9'h055, 8'h00, 1'b0);
    #2;
    check("t6_tie_gnt0", gnt0, 1);
    check("t6_tie_gnt1", gnt1, 0);
    tick();
    idle();
    #2;
    check("t6_rvalid0", rvalid0, 1);
    check("t6_rdata", rdata, pre(32'h055));
    tick();
    tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
